song_sequencer: RTL
===================

// Module: song_sequencer
// PURPOSE
//  Consumes the quarter-beat toggle from the beat generator and steps through a song table.
//  Each table entry is a {note, duration} pair; the block holds each note for its duration in quarter beats.
//  It drives the note code and gate to the downstream tone generator.
//  PLAY is pause/resume, STOP is reset-to-start, and SONG_DONE flags the end-of-song marker.
// PARAMETERS
//  ADDR_W  5  song table address width (2**ADDR_W entries)
//  NOTE_W  4  note code width; code 0 = rest
//  DUR_W   3  duration field width, in quarter beats; 0 = end-of-song marker
// PORTS
//  CLK          in   1              system clock
//  RESET        in   1              asynchronous, active-high reset
//  BEAT_TOGGLE  in   1              quarter-beat signal; each edge (rise or fall) = one beat
//  PLAY         in   1              level: 1 = run, 0 = pause
//  STOP         in   1              synchronous pulse: abort, return to start
//  ROM_ADDR     out  ADDR_W         song table address (registered)
//  ROM_DATA     in   NOTE_W+DUR_W   {note, dur}; combinational read of ROM_ADDR
//  NOTE         out  NOTE_W         current note code
//  NOTE_ON      out  1              gate: current entry is a sounding, unpaused note
//  SONG_DONE    out  1              one-cycle pulse when the end marker is fetched
//  BUSY         out  1              1 in FETCH or HOLD
// BEHAVIOUR
//  - Reset values: ROM_ADDR=0, NOTE=0, NOTE_ON=0, SONG_DONE=0, BUSY=0, state=IDLE.
//    Internal reset: beat_q=0, beat_cnt=0.
//  - Beat tick: beat_q <= BEAT_TOGGLE every cycle; tick = BEAT_TOGGLE ^ beat_q.
//    Exactly one tick per toggle edge.
//  - FSM states: IDLE, FETCH, HOLD, DONE. All outputs are registered.
//  - IDLE:
//    - ROM_ADDR=0, NOTE=0, NOTE_ON=0.
//    - PLAY=1 -> FETCH.
//  - FETCH (exactly 1 cycle): sample ROM_DATA.
//    - dur==0: SONG_DONE=1 for one cycle, NOTE_ON=0 -> DONE.
//    - Else: NOTE<=note, NOTE_ON<=(note!=0), beat_cnt<=dur -> HOLD.
//    - Latency: PLAY sampled high in IDLE at cycle N -> NOTE/NOTE_ON valid from cycle N+2.
//    - A tick during FETCH is ignored.
//  - HOLD, PLAY=1: on each tick, beat_cnt decrements.
//    - On the tick where beat_cnt==1: ROM_ADDR<=ROM_ADDR+1 -> FETCH.
//    - ROM_ADDR wraps from 2**ADDR_W-1 to 0.
//  - HOLD, PLAY=0 (pause):
//    - Ticks ignored; beat_cnt, NOTE and ROM_ADDR are retained.
//    - NOTE_ON forced 0 from the next cycle.
//    - Resume restores NOTE_ON=(NOTE!=0) and continues with the remaining beats.
//  - DONE:
//    - NOTE=0, NOTE_ON=0, ROM_ADDR stays at the marker address.
//    - Stays in DONE while PLAY=1; PLAY=0 -> IDLE. Holding PLAY never replays the song.
//  - STOP has highest priority, in any state:
//    - Next cycle is IDLE with ROM_ADDR=0, NOTE=0, NOTE_ON=0, beat_cnt=0, SONG_DONE=0.
//    - STOP and PLAY in the same cycle: STOP wins; FETCH follows on the next cycle if PLAY is still 1.
//  - RESET mid-song returns to the reset values immediately.
//  - BUSY=1 iff state is FETCH or HOLD.
// CONFIGURATION
//  SEQ_LOOP_EN defined:
//    - A FETCH of dur==0 pulses SONG_DONE, sets ROM_ADDR<=0 and goes to FETCH, not DONE.
//    - The song repeats until STOP or RESET; the DONE state is unreachable.
//    - A table whose entry 0 is a marker pulses SONG_DONE every 2 cycles.
//  SEQ_LOOP_EN undefined: behaviour as above (DONE terminal until PLAY=0).
// TESTING
//  1 Assert RESET mid-run -> all outputs at reset values; BUSY=0; ROM_ADDR=0.
//  2 Table {5,2},{3,1},{0,0}, PLAY=1, BEAT_TOGGLE flips every 9 clocks:
//    - NOTE=5 for 2 ticks, then NOTE=3 for 1 tick.
//    - Then a single SONG_DONE pulse, ROM_ADDR=2, NOTE_ON=0, state DONE.
//  3 Entry {0,1} -> NOTE=0, NOTE_ON=0 for one tick, then advance to the next address.
//  4 Entry {7,3}: drop PLAY after 1 tick, apply 5 toggles, raise PLAY:
//    - During pause: NOTE_ON=0, ROM_ADDR frozen.
//    - After resume: NOTE_ON=1, advance after 2 more ticks.
//  5 STOP during HOLD at ROM_ADDR=1 -> next cycle IDLE, ROM_ADDR=0, NOTE_ON=0.
//    STOP+PLAY in the same cycle -> IDLE, then FETCH one cycle later.
//  6 With SEQ_LOOP_EN and test-2 table:
//    - After the marker, ROM_ADDR=0 and NOTE=5 again; SONG_DONE pulses each pass.
//    - A full 32-entry table with no marker wraps from ROM_ADDR 31 to 0.

Source files
------------

// File: rtl/song_sequencer.sv
// Song table sequencer: steps {note, duration} entries on quarter-beat ticks and drives note/gate.
// Optional SEQ_LOOP_EN: the end marker restarts the song from address 0 instead of stopping.
module song_sequencer #(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BEAT_TOGGLE,
  input  logic                    PLAY,
  input  logic                    STOP,
  output logic [ADDR_W-1:0]       ROM_ADDR,
  input  logic [NOTE_W+DUR_W-1:0] ROM_DATA,
  output logic [NOTE_W-1:0]       NOTE,
  output logic                    NOTE_ON,
  output logic                    SONG_DONE,
  output logic                    BUSY,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                beat_q;
  logic                tick;
  logic [DUR_W-1:0]    beat_cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [NOTE_W-1:0]   note_d;
  logic                note_on_d, done_d, busy_d;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                marker;

  assign rom_note  = ROM_DATA[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = ROM_DATA[DUR_W-1:0];
  assign marker    = (rom_dur == '0);
  assign tick      = BEAT_TOGGLE ^ beat_q;
  assign dbg_state = state_q;

  // State and all registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      beat_q    <= 1'b0;
      beat_cnt  <= '0;
      ROM_ADDR  <= '0;
      NOTE      <= '0;
      NOTE_ON   <= 1'b0;
      SONG_DONE <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= BEAT_TOGGLE;
      beat_cnt  <= cnt_d;
      ROM_ADDR  <= addr_d;
      NOTE      <= note_d;
      NOTE_ON   <= note_on_d;
      SONG_DONE <= done_d;
      BUSY      <= busy_d;
    end
  end

  // Next-state logic; STOP overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (PLAY) state_d = S_FETCH;
      S_FETCH: begin
        if (marker) begin
`ifdef SEQ_LOOP_EN
          state_d = S_FETCH;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:  if (PLAY && tick && beat_cnt == DUR_W'(1)) state_d = S_FETCH;
      S_DONE:  if (!PLAY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (STOP) state_d = S_IDLE;
  end

  // Next values of the registered outputs and beat counter
  always_comb begin
    addr_d    = ROM_ADDR;
    note_d    = NOTE;
    note_on_d = NOTE_ON;
    done_d    = 1'b0;
    cnt_d     = beat_cnt;
    case (state_q)
      S_FETCH: begin
        if (marker) begin
          note_d    = '0;
          note_on_d = 1'b0;
`ifdef SEQ_LOOP_EN
          // A marker at entry 0 refetches every cycle; alternate so SONG_DONE stays a pulse.
          done_d    = !SONG_DONE;
          addr_d    = '0;
`else
          done_d    = 1'b1;
`endif
        end else begin
          note_d    = rom_note;
          note_on_d = (rom_note != '0);
          cnt_d     = rom_dur;
        end
      end
      S_HOLD: begin
        if (PLAY) begin
          note_on_d = (NOTE != '0);
          if (tick) begin
            cnt_d = beat_cnt - DUR_W'(1);
            if (beat_cnt == DUR_W'(1)) addr_d = ROM_ADDR + ADDR_W'(1);
          end
        end else begin
          note_on_d = 1'b0;
        end
      end
      S_DONE: begin
        note_d    = '0;
        note_on_d = 1'b0;
      end
      default: ;
    endcase
    if (state_d == S_IDLE) begin
      addr_d    = '0;
      note_d    = '0;
      note_on_d = 1'b0;
    end
    if (STOP) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_HOLD);
  end

endmodule
